// File: rtl/arb_req_pkg.sv
// -----------------------------------------------------------------------------
// arb_req_pkg
// Shared types and constants for the arbiter requester client.
//   arb_req_state_e : requester FSM state encoding
//   DEFAULT_TIMEOUT : default REQ-phase abort limit, in clock cycles
//   timer_width()   : bit width needed to hold a timeout count of 0..timeout
// -----------------------------------------------------------------------------
package arb_req_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    OWN  = 2'b10,
    REL  = 2'b11
  } arb_req_state_e;

  localparam int DEFAULT_TIMEOUT = 64;

  function automatic int timer_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/arb_req_timer.sv
// -----------------------------------------------------------------------------
// arb_req_timer
// Down-counter that bounds how long the requester may wait for a grant.
// Loaded with TIMEOUT when a job is accepted, decremented once per REQ cycle,
// and flags expiry on the TIMEOUT-th enabled cycle (count == 1).
// Ports:
//   i_clk      clock, rising edge
//   i_resetn   synchronous active-low reset
//   i_load     reload the counter with TIMEOUT
//   i_en       count this cycle (requester is in REQ)
//   o_expired  terminal count reached while enabled
// -----------------------------------------------------------------------------
module arb_req_timer
  import arb_req_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int W = timer_width(TIMEOUT);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= W'(TIMEOUT);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  // Count of 1 marks the last permitted REQ cycle; saturation at 0 prevents wrap.
  assign o_expired = i_en && (r_cnt == W'(1));

endmodule

// File: rtl/arb_requester.sv
// -----------------------------------------------------------------------------
// arb_requester
// Device-side client of the 3-way request/grant arbiter. Accepts a burst job,
// raises req, waits for gnt, streams job_len beats from the source onto the
// shared bus, then drops req and waits for gnt to fall before the next job so
// a stale registered grant is never reused.
//
// Build option: ARB_REQ_TIMEOUT_EN -- when defined, a REQ-phase timer aborts
// the job after TIMEOUT cycles without a grant. When undefined, REQ waits for
// the grant indefinitely and no timer is built.
//
// Parameters: DATA_W (bus width), LEN_W (job length width), TIMEOUT (>= 1)
// Ports:
//   i_clk, i_resetn            clock (rising edge), synchronous active-low reset
//   i_job_valid, i_job_len     job offer and beat count (0 = empty job)
//   o_job_ready                combinational, high only in IDLE
//   i_src_valid, i_src_data    source beat
//   o_src_ready                combinational, high only in OWN
//   o_req / i_gnt              request to / grant from the arbiter
//   o_bus_valid, o_bus_data    registered bus beat
//   o_done, o_err              1-cycle job-finished pulse; err marks an abort
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a job; empty jobs finish here directly
// REQ   | req high, waiting for the grant (optionally time-limited)
// OWN   | bus owned, forwarding source beats until the count runs out
// REL   | req low, waiting for the grant to fall before reporting done
// -----------------------------------------------------------------------------
module arb_requester
  import arb_req_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_job_valid,
  input  logic [LEN_W-1:0]  i_job_len,
  output logic              o_job_ready,
  input  logic              i_src_valid,
  input  logic [DATA_W-1:0] i_src_data,
  output logic              o_src_ready,
  output logic              o_req,
  input  logic              i_gnt,
  output logic              o_bus_valid,
  output logic [DATA_W-1:0] o_bus_data,
  output logic              o_done,
  output logic              o_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("arb_requester: TIMEOUT must be at least 1");
  end

  arb_req_state_e    r_state;
  logic              r_req;
  logic              r_bus_valid;
  logic [DATA_W-1:0] r_bus_data;
  logic              r_done;
  logic              r_err;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_abort;

  arb_req_state_e    w_state_nxt;
  logic              w_req_nxt;
  logic              w_bus_valid_nxt;
  logic [DATA_W-1:0] w_bus_data_nxt;
  logic              w_done_nxt;
  logic              w_err_nxt;
  logic [LEN_W-1:0]  w_cnt_nxt;
  logic              w_abort_nxt;
  logic              w_last_beat;
  logic              w_tmr_expired;

`ifdef ARB_REQ_TIMEOUT_EN
  logic w_tmr_load;
  logic w_tmr_en;

  assign w_tmr_load = (r_state == IDLE) && i_job_valid && (i_job_len != '0);
  assign w_tmr_en   = (r_state == REQ);

  arb_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk     (i_clk),
    .i_resetn  (i_resetn),
    .i_load    (w_tmr_load),
    .i_en      (w_tmr_en),
    .o_expired (w_tmr_expired)
  );
`else
  assign w_tmr_expired = 1'b0;
`endif

  assign w_last_beat = i_src_valid && (r_cnt == LEN_W'(1));

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state     <= IDLE;
      r_req       <= 1'b0;
      r_bus_valid <= 1'b0;
      r_bus_data  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_abort     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      r_bus_valid <= w_bus_valid_nxt;
      r_bus_data  <= w_bus_data_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_cnt       <= w_cnt_nxt;
      r_abort     <= w_abort_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_req_nxt       = r_req;
    w_bus_valid_nxt = 1'b0;
    w_bus_data_nxt  = r_bus_data;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_cnt_nxt       = r_cnt;
    w_abort_nxt     = r_abort;
    o_job_ready     = 1'b0;
    o_src_ready     = 1'b0;

    case (r_state)
      IDLE: begin
        o_job_ready = 1'b1;
        w_abort_nxt = 1'b0;
        if (i_job_valid) begin
          if (i_job_len != '0) begin
            w_cnt_nxt   = i_job_len;
            w_req_nxt   = 1'b1;
            w_state_nxt = REQ;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end

      REQ: begin
        // A grant seen in the expiry cycle still wins.
        if (i_gnt) begin
          w_state_nxt = OWN;
        end else if (w_tmr_expired) begin
          w_req_nxt   = 1'b0;
          w_abort_nxt = 1'b1;
          w_state_nxt = REL;
        end
      end

      OWN: begin
        o_src_ready = 1'b1;
        if (i_src_valid) begin
          w_bus_valid_nxt = 1'b1;
          w_bus_data_nxt  = i_src_data;
          w_cnt_nxt       = r_cnt - LEN_W'(1);
        end
        // Source beats offered while src_ready is high are always taken;
        // losing the grant aborts unless this cycle completes the burst.
        if (w_last_beat) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = REL;
        end else if (!i_gnt) begin
          w_req_nxt   = 1'b0;
          w_abort_nxt = 1'b1;
          w_state_nxt = REL;
        end
      end

      REL: begin
        w_req_nxt = 1'b0;
        if (!i_gnt) begin
          w_done_nxt  = 1'b1;
          w_err_nxt   = r_abort;
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_req       = r_req;
  assign o_bus_valid = r_bus_valid;
  assign o_bus_data  = r_bus_data;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule
